fifo_drain_ctrl: RTL and testbench

//   Read-side controller for the 8x16 transfer buffer, on the clk_2 domain.
//   - Pops words from the buffer one at a time.
//   - Absorbs the buffer read latency.
//   - Presents each word downstream with a valid/ready handshake.
//   - Counts words and marks frame boundaries every BURST_LEN words.

---
 rtl/fifo_drain_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pops the transfer buffer, hides read latency and
// hands words downstream over valid/ready. Optional frame checksum via CHECKSUM_EN.
module fifo_drain_ctrl #(
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 3
) (
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [DATA_W-1:0] data_2,
  output logic              data_2_valid,
  input  logic              data_2_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              frame_done
`ifdef CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int LAT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fd_q, fd_d;
  logic                xfer;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   cks_q, cks_d;
`endif

  assign xfer = valid_q & data_2_ready;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
`ifdef CHECKSUM_EN
      acc_q   <= '0;
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
`ifdef CHECKSUM_EN
      acc_q   <= acc_d;
      cks_q   <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    data_d     = data_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    fd_d       = 1'b0;
    fifo_rd_en = 1'b0;
`ifdef CHECKSUM_EN
    acc_d      = acc_q;
    cks_d      = cks_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_POP;
      end
      S_POP: begin
        // Gate on empty so a flag that rises mid-cycle can never cause a pop of nothing.
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          lat_d      = LAT_W'(RD_LAT - 1);
          state_d    = S_WAIT;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          data_d  = fifo_rd_data;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          lat_d   = lat_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (xfer) begin
          valid_d = 1'b0;
          state_d = fifo_empty ? S_IDLE : S_POP;
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            cnt_d = '0;
            fd_d  = 1'b1;
`ifdef CHECKSUM_EN
            cks_d = acc_q + data_q;
            acc_d = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
`ifdef CHECKSUM_EN
            acc_d = acc_q + data_q;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_2       = data_q;
  assign data_2_valid = valid_q;
  assign word_cnt     = cnt_q;
  assign frame_done   = fd_q;
`ifdef CHECKSUM_EN
  assign checksum     = cks_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: instance A (RD_LAT=1) fed by a small
// buffer model, instance B (RD_LAT=3) fed by a 3-stage read-data pipe.
module tb_fifo_drain_ctrl;

  logic clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  logic        rst_n        = 1'b0;
  logic        data_2_ready = 1'b0;

  // Instance A and its buffer model
  logic [15:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = 16'h0000;
  logic [15:0] data_2;
  logic        data_2_valid;
  logic [2:0]  word_cnt;
  logic        frame_done;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk_2) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Instance B: word appears on rd_data exactly 3 cycles after the sampled pop
  logic        empty_b = 1'b1;
  logic        rd_en_b;
  logic [15:0] d1_b = 16'hDEAD;
  logic [15:0] d2_b = 16'hDEAD;
  logic [15:0] rd_data_b = 16'hDEAD;
  logic [15:0] data_b;
  logic        valid_b;
  logic [2:0]  cnt_b;
  logic        fd_b;

  always @(posedge clk_2) begin
    d1_b      <= rd_en_b ? 16'h3C3C : 16'hDEAD;
    d2_b      <= d1_b;
    rd_data_b <= d2_b;
  end

`ifdef CHECKSUM_EN
  logic [15:0] checksum;
  logic [15:0] checksum_b;
`endif

  fifo_drain_ctrl #(.DATA_W(16), .RD_LAT(1), .BURST_LEN(8), .CNT_W(3)) dut_a (
    .clk_2        (clk_2),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .data_2       (data_2),
    .data_2_valid (data_2_valid),
    .data_2_ready (data_2_ready),
    .word_cnt     (word_cnt),
    .frame_done   (frame_done)
`ifdef CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  fifo_drain_ctrl #(.DATA_W(16), .RD_LAT(3), .BURST_LEN(8), .CNT_W(3)) dut_b (
    .clk_2        (clk_2),
    .rst_n        (rst_n),
    .fifo_empty   (empty_b),
    .fifo_rd_en   (rd_en_b),
    .fifo_rd_data (rd_data_b),
    .data_2       (data_b),
    .data_2_valid (valid_b),
    .data_2_ready (data_2_ready),
    .word_cnt     (cnt_b),
    .frame_done   (fd_b)
`ifdef CHECKSUM_EN
    ,
    .checksum     (checksum_b)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Entered at the negedge just after a frame's first capture edge.
  task automatic check_frame(input logic [15:0] base, input logic [15:0] step,
                             input logic [15:0] exp_sum, input logic [15:0] prev_sum);
    logic [15:0] w;
    logic [15:0] s;
    for (int k = 1; k <= 8; k++) begin
      w = base + step * 16'(k - 1);
      s = (k == 8) ? exp_sum : prev_sum;
      chk("frm_valid", 32'(data_2_valid), 32'd1);
      chk("frm_data", 32'(data_2), 32'(w));
      cyc(1);
      chk("frm_cnt", 32'(word_cnt), 32'(k % 8));
      chk("frm_done", 32'(frame_done), (k == 8) ? 32'd1 : 32'd0);
`ifdef CHECKSUM_EN
      chk("frm_sum", 32'(checksum), 32'(s));
`endif
      cyc(2);
    end
  endtask

  initial begin
    // Reset state
    cyc(1);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(data_2_valid), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_data", 32'(data_2), 32'd0);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_no_pop", 32'(fifo_rd_en), 32'd0);

    // Single word, RD_LAT=1
    data_2_ready = 1'b1;
    push(16'hA5A5);
    cyc(1);
    chk("sw_rd_en", 32'(fifo_rd_en), 32'd1);
    chk("sw_valid_e1", 32'(data_2_valid), 32'd0);
    cyc(1);
    chk("sw_rd_en_off", 32'(fifo_rd_en), 32'd0);
    chk("sw_valid_e2", 32'(data_2_valid), 32'd0);
    cyc(1);
    chk("sw_valid_e3", 32'(data_2_valid), 32'd1);
    chk("sw_data", 32'(data_2), 32'h0000A5A5);
    chk("sw_cnt_before", 32'(word_cnt), 32'd0);
    cyc(1);
    chk("sw_valid_drop", 32'(data_2_valid), 32'd0);
    chk("sw_cnt", 32'(word_cnt), 32'd1);
    chk("sw_data_held", 32'(data_2), 32'h0000A5A5);
    cyc(2);
    chk("sw_idle", 32'(fifo_rd_en), 32'd0);

    // Backpressure
    data_2_ready = 1'b0;
    push(16'h1234);
    push(16'h5678);
    cyc(3);
    chk("bp_valid", 32'(data_2_valid), 32'd1);
    chk("bp_data", 32'(data_2), 32'h00001234);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bp_hold_data", 32'(data_2), 32'h00001234);
      chk("bp_hold_valid", 32'(data_2_valid), 32'd1);
      chk("bp_no_pop", 32'(fifo_rd_en), 32'd0);
    end
    data_2_ready = 1'b1;
    cyc(1);
    chk("bp_xfer_valid", 32'(data_2_valid), 32'd0);
    chk("bp_next_pop", 32'(fifo_rd_en), 32'd1);
    chk("bp_cnt", 32'(word_cnt), 32'd2);
    cyc(2);
    chk("bp_w2_valid", 32'(data_2_valid), 32'd1);
    chk("bp_w2_data", 32'(data_2), 32'h00005678);
    cyc(1);
    chk("bp_w2_cnt", 32'(word_cnt), 32'd3);
    chk("bp_w2_idle", 32'(fifo_rd_en), 32'd0);

    // Asynchronous reset while holding a word
    data_2_ready = 1'b0;
    push(16'hBEEF);
    cyc(3);
    chk("ar_hold_valid", 32'(data_2_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("ar_valid", 32'(data_2_valid), 32'd0);
    chk("ar_cnt", 32'(word_cnt), 32'd0);
    chk("ar_done", 32'(frame_done), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    data_2_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("ar_post_no_pop", 32'(fifo_rd_en), 32'd0);
      chk("ar_post_valid", 32'(data_2_valid), 32'd0);
    end

    // Frame of 1..8
    for (int k = 1; k <= 8; k++) push(16'(k));
    cyc(3);
    check_frame(16'd1, 16'd1, 16'd36, 16'd0);
    chk("frm1_done_pulse", 32'(frame_done), 32'd0);

    // Back-to-back frames: FFFF x8 then 1..8
    for (int k = 1; k <= 8; k++) push(16'hFFFF);
    for (int k = 1; k <= 8; k++) push(16'(k));
    cyc(3);
    check_frame(16'hFFFF, 16'd0, 16'hFFF8, 16'd36);
    check_frame(16'd1, 16'd1, 16'd36, 16'hFFF8);
    chk("frm3_done_pulse", 32'(frame_done), 32'd0);

    // Empty guard
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      chk("eg_a", 32'(fifo_rd_en), 32'd0);
      chk("eg_b", 32'(rd_en_b), 32'd0);
    end

    // RD_LAT=3 capture timing on instance B
    empty_b = 1'b0;
    cyc(1);
    chk("l3_rd_en", 32'(rd_en_b), 32'd1);
    cyc(1);
    empty_b = 1'b1;
    chk("l3_e2_valid", 32'(valid_b), 32'd0);
    cyc(1);
    empty_b = 1'b0;
    chk("l3_e3_valid", 32'(valid_b), 32'd0);
    chk("l3_wait_no_pop", 32'(rd_en_b), 32'd0);
    cyc(1);
    empty_b = 1'b1;
    chk("l3_e4_valid", 32'(valid_b), 32'd0);
    cyc(1);
    chk("l3_e5_valid", 32'(valid_b), 32'd1);
    chk("l3_data", 32'(data_b), 32'h00003C3C);
    cyc(1);
    chk("l3_xfer_valid", 32'(valid_b), 32'd0);
    chk("l3_cnt", 32'(cnt_b), 32'd1);
    chk("l3_done", 32'(fd_b), 32'd0);
    cyc(2);
    chk("l3_idle", 32'(rd_en_b), 32'd0);
`ifdef CHECKSUM_EN
    chk("l3_sum", 32'(checksum_b), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
